vga_sync_gen: RTL and testbench

Pixel-timing generator for the 640x480@60 display path. It drives the `DrawX`/`DrawY` scan coordinates and the `blank` qualifier that background and sprite renderers consume. It also drives the monitor sync pulses. Each renderer performs a registered ROM lookup and registers its colour output, so the block also provides copies of the sync and blank signals delayed by a parameterised number of cycles. These copies arrive at the VGA pins aligned with the colour data.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_sync_gen_if.sv | 24 ++
 rtl/sync_delay_line.sv | 38 +++
 rtl/vga_sync_gen.sv | 106 ++++++++++
 tb/tb_vga_sync_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and the scan-coordinate type.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned PIPE_DELAY_DEF = 2;
  localparam int unsigned PIPE_DELAY_MAX = 4;

  // Total length of a line (pixels) or frame (lines) from its four segments.
  function automatic int unsigned span_total(input int unsigned visible,
                                             input int unsigned fp,
                                             input int unsigned sync_w,
                                             input int unsigned bp);
    return visible + fp + sync_w + bp;
  endfunction

  localparam int unsigned H_TOTAL = span_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL = span_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Scan position, sync and blanking bundle from the timing generator to renderers and pins.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   hs;
  logic   vs;
  logic   blank;
  logic   sync;
  logic   frame_start;
  logic   hs_d;
  logic   vs_d;
  logic   blank_d;

  modport master (
    output DrawX, DrawY, hs, vs, blank, sync, frame_start, hs_d, vs_d, blank_d
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, sync, frame_start, hs_d, vs_d, blank_d
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that realigns sync/blank with the renderer colour pipeline.
module sync_delay_line #(
  parameter int unsigned     WIDTH     = 3,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Every stage reloads the idle pattern so the output stays idle for DEPTH cycles
    // after reset release.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running pixel/line counters with registered sync, blank and frame-start decode.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic           vga_clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned HTotal = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam coord_t HLast   = coord_t'(HTotal - 1);
  localparam coord_t VLast   = coord_t'(VTotal - 1);
  localparam coord_t HVisEnd = coord_t'(H_VISIBLE);
  localparam coord_t VVisEnd = coord_t'(V_VISIBLE);
  localparam coord_t HsStart = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HsEnd   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VsStart = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VsEnd   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic [2:0] IdleSyncs = 3'b110;  // {hs, vs, blank}

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   blank_q, blank_d;
  logic   frame_start_q, frame_start_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (x_q == HLast) begin
      x_d = '0;
      y_d = (y_q == VLast) ? '0 : y_q + coord_t'(1);
    end else begin
      x_d = x_q + coord_t'(1);
    end
  end

  // Decode from the next position so registered flags line up with DrawX/DrawY.
  always_comb begin
    hs_d          = ~((x_d >= HsStart) && (x_d < HsEnd));
    vs_d          = ~((y_d >= VsStart) && (y_d < VsEnd));
    blank_d       = (x_d < HVisEnd) && (y_d < VVisEnd);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

  // Reset parks the scan on the last pixel of a frame so release lands on (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q           <= HLast;
      y_q           <= VLast;
      hs_q          <= IdleSyncs[2];
      vs_q          <= IdleSyncs[1];
      blank_q       <= IdleSyncs[0];
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  logic [2:0] pipe_in;
  logic [2:0] pipe_out;

  assign pipe_in = {hs_q, vs_q, blank_q};

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (IdleSyncs)
  ) u_delay (
    .clk   (vga_clk),
    .reset (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.sync        = 1'b0;
  assign vga.frame_start = frame_start_q;
  assign vga.hs_d        = pipe_out[2];
  assign vga.vs_d        = pipe_out[1];
  assign vga.blank_d     = pipe_out[0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full 640x480 instance for line timing, reduced-timing instances for frames.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_big;
  logic rst_small;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if big_if ();
  vga_sync_gen_if s0_if ();
  vga_sync_gen_if s2_if ();
  vga_sync_gen_if s4_if ();

  vga_sync_gen u_big (.vga_clk(clk), .reset(rst_big), .vga(big_if));

  // Reduced timing: line 10+2+3+5 = 20 pixels, frame 6+1+2+3 = 12 lines (240 cycles).
  vga_sync_gen #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(0)
  ) u_s0 (.vga_clk(clk), .reset(rst_small), .vga(s0_if));

  vga_sync_gen #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2)
  ) u_s2 (.vga_clk(clk), .reset(rst_small), .vga(s2_if));

  vga_sync_gen #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(4)
  ) u_s4 (.vga_clk(clk), .reset(rst_small), .vga(s4_if));

  // Reference position for the reduced-timing instances; hist[k] = {hs,vs,blank} k cycles ago.
  coord_t     mx;
  coord_t     my;
  logic [2:0] hist [5];
  logic       exp_fs;

  function automatic logic [2:0] small_decode(input coord_t x, input coord_t y);
    logic h, v, b;
    h = !((x >= 10'd12) && (x <= 10'd14));
    v = !((y >= 10'd7) && (y <= 10'd8));
    b = (x < 10'd10) && (y < 10'd6);
    return {h, v, b};
  endfunction

  task automatic model_reset();
    mx = 10'd19;
    my = 10'd11;
    for (int k = 0; k < 5; k++) hist[k] = 3'b110;
  endtask

  task automatic model_step();
    if (mx == 10'd19) begin
      mx = 10'd0;
      my = (my == 10'd11) ? 10'd0 : my + 10'd1;
    end else begin
      mx = mx + 10'd1;
    end
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = small_decode(mx, my);
    exp_fs  = (mx == 10'd0) && (my == 10'd0);
  endtask

  task automatic test_reset();
    rst_big   = 1'b1;
    rst_small = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    tests++;
    if (big_if.DrawX !== 10'd799) begin
      fails++; $display("FAIL reset_drawx: got %0d want 799", big_if.DrawX);
    end
    tests++;
    if (big_if.DrawY !== 10'd524) begin
      fails++; $display("FAIL reset_drawy: got %0d want 524", big_if.DrawY);
    end
    tests++;
    if ({big_if.hs, big_if.vs, big_if.blank, big_if.frame_start, big_if.sync} !== 5'b11000) begin
      fails++;
      $display("FAIL reset_flags: got hs/vs/blank/fs/sync=%b want 11000",
               {big_if.hs, big_if.vs, big_if.blank, big_if.frame_start, big_if.sync});
    end
    tests++;
    if ({big_if.hs_d, big_if.vs_d, big_if.blank_d} !== 3'b110) begin
      fails++;
      $display("FAIL reset_delayed: got %b want 110", {big_if.hs_d, big_if.vs_d, big_if.blank_d});
    end
    tests++;
    if ({s4_if.DrawX, s4_if.DrawY} !== {10'd19, 10'd11}) begin
      fails++; $display("FAIL reset_small_pos: got (%0d,%0d) want (19,11)", s4_if.DrawX, s4_if.DrawY);
    end
  endtask

  task automatic test_release();
    rst_big = 1'b0;
    @(negedge clk);
    tests++;
    if ({big_if.DrawX, big_if.DrawY} !== 20'd0) begin
      fails++; $display("FAIL release_pos: got (%0d,%0d) want (0,0)", big_if.DrawX, big_if.DrawY);
    end
    tests++;
    if ({big_if.hs, big_if.vs, big_if.blank, big_if.frame_start} !== 4'b1111) begin
      fails++;
      $display("FAIL release_flags: got hs/vs/blank/fs=%b want 1111",
               {big_if.hs, big_if.vs, big_if.blank, big_if.frame_start});
    end
    tests++;
    if (big_if.blank_d !== 1'b0) begin
      fails++; $display("FAIL release_blank_d0: got %b want 0", big_if.blank_d);
    end
    @(negedge clk);
    tests++;
    if ({big_if.DrawX, big_if.frame_start, big_if.blank_d} !== {10'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL release_second: got x=%0d fs=%b blank_d=%b want x=1 fs=0 blank_d=0",
               big_if.DrawX, big_if.frame_start, big_if.blank_d);
    end
    @(negedge clk);
    tests++;
    if ({big_if.DrawX, big_if.blank_d} !== {10'd2, 1'b1}) begin
      fails++;
      $display("FAIL release_third: got x=%0d blank_d=%b want x=2 blank_d=1",
               big_if.DrawX, big_if.blank_d);
    end
  endtask

  task automatic test_line();
    int   prev_x     = 2;
    int   blank_fall = -1;
    int   hs_first   = -1;
    int   hs_last    = -1;
    int   hs_count   = 0;
    int   step_errs  = 0;
    bit   wrapped    = 1'b0;
    int   xm2;
    logic exp_hs_d, exp_blank_d;
    for (int c = 0; c < 900 && !wrapped; c++) begin
      @(negedge clk);
      if (big_if.DrawX !== coord_t'((prev_x + 1) % 800)) step_errs++;
      if (big_if.DrawX == 10'd0) begin
        wrapped = 1'b1;
        tests++;
        if (big_if.DrawY !== 10'd1) begin
          fails++; $display("FAIL line_y_inc: got %0d want 1", big_if.DrawY);
        end
      end else if (big_if.DrawY !== 10'd0) begin
        step_errs++;
      end
      if (big_if.blank === 1'b0 && blank_fall < 0) blank_fall = int'(big_if.DrawX);
      if (big_if.hs === 1'b0) begin
        if (hs_first < 0) hs_first = int'(big_if.DrawX);
        hs_last = int'(big_if.DrawX);
        hs_count++;
      end
      xm2         = (int'(big_if.DrawX) + 798) % 800;
      exp_hs_d    = !((xm2 >= 656) && (xm2 <= 751));
      exp_blank_d = (xm2 < 640);
      tests++;
      if ({big_if.hs_d, big_if.blank_d} !== {exp_hs_d, exp_blank_d}) begin
        fails++;
        $display("FAIL line_delayed x=%0d: got hs_d/blank_d=%b%b want %b%b", big_if.DrawX,
                 big_if.hs_d, big_if.blank_d, exp_hs_d, exp_blank_d);
      end
      prev_x = int'(big_if.DrawX);
    end
    tests++;
    if (!wrapped) begin
      fails++; $display("FAIL line_wrap: got no wrap within 900 cycles want wrap");
    end
    tests++;
    if (step_errs != 0) begin
      fails++; $display("FAIL line_count_step: got %0d bad steps want 0", step_errs);
    end
    tests++;
    if (blank_fall != 640) begin
      fails++; $display("FAIL line_blank_fall: got x=%0d want 640", blank_fall);
    end
    tests++;
    if (hs_first != 656 || hs_last != 751 || hs_count != 96) begin
      fails++;
      $display("FAIL line_hsync: got %0d..%0d count %0d want 656..751 count 96",
               hs_first, hs_last, hs_count);
    end
  endtask

  task automatic test_mid_reset_big();
    bit found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (big_if.DrawX == 10'd300) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL big_reach_300: got x=%0d want 300", big_if.DrawX);
    end
    rst_big = 1'b1;
    @(negedge clk);
    tests++;
    if ({big_if.DrawX, big_if.DrawY, big_if.hs, big_if.vs, big_if.blank, big_if.frame_start,
         big_if.hs_d, big_if.vs_d, big_if.blank_d} !== {10'd799, 10'd524, 7'b1100110}) begin
      fails++;
      $display("FAIL big_mid_reset: got (%0d,%0d) flags=%b want (799,524) flags=1100110",
               big_if.DrawX, big_if.DrawY, {big_if.hs, big_if.vs, big_if.blank,
               big_if.frame_start, big_if.hs_d, big_if.vs_d, big_if.blank_d});
    end
    rst_big = 1'b0;
    @(negedge clk);
    tests++;
    if ({big_if.DrawX, big_if.DrawY, big_if.frame_start} !== {20'd0, 1'b1}) begin
      fails++;
      $display("FAIL big_mid_release: got (%0d,%0d) fs=%b want (0,0) fs=1",
               big_if.DrawX, big_if.DrawY, big_if.frame_start);
    end
  endtask

  task automatic test_small_frames();
    int fs_cyc [$];
    int vs_f1 = 0, vs_f2 = 0, vs_first = -1, vs_last = -1;
    int bl_f1 = 0, bl_f2 = 0;
    rst_small = 1'b0;
    for (int c = 1; c <= 482; c++) begin
      @(negedge clk);
      model_step();
      tests++;
      if ({s0_if.DrawX, s0_if.DrawY, s0_if.hs, s0_if.vs, s0_if.blank, s0_if.frame_start,
           s0_if.sync} !== {mx, my, hist[0], exp_fs, 1'b0}) begin
        fails++;
        $display("FAIL frame_s0_main c=%0d: got (%0d,%0d) %b%b want (%0d,%0d) %b%b", c,
                 s0_if.DrawX, s0_if.DrawY, {s0_if.hs, s0_if.vs, s0_if.blank},
                 s0_if.frame_start, mx, my, hist[0], exp_fs);
      end
      tests++;
      if ({s2_if.DrawX, s2_if.DrawY, s2_if.hs, s2_if.vs, s2_if.blank, s2_if.frame_start}
          !== {mx, my, hist[0], exp_fs}) begin
        fails++;
        $display("FAIL frame_s2_main c=%0d: got (%0d,%0d) %b%b want (%0d,%0d) %b%b", c,
                 s2_if.DrawX, s2_if.DrawY, {s2_if.hs, s2_if.vs, s2_if.blank},
                 s2_if.frame_start, mx, my, hist[0], exp_fs);
      end
      tests++;
      if ({s0_if.hs_d, s0_if.vs_d, s0_if.blank_d} !== hist[0]) begin
        fails++;
        $display("FAIL frame_delay0 c=%0d: got %b want %b", c,
                 {s0_if.hs_d, s0_if.vs_d, s0_if.blank_d}, hist[0]);
      end
      tests++;
      if ({s2_if.hs_d, s2_if.vs_d, s2_if.blank_d} !== hist[2]) begin
        fails++;
        $display("FAIL frame_delay2 c=%0d: got %b want %b", c,
                 {s2_if.hs_d, s2_if.vs_d, s2_if.blank_d}, hist[2]);
      end
      tests++;
      if ({s4_if.hs_d, s4_if.vs_d, s4_if.blank_d} !== hist[4]) begin
        fails++;
        $display("FAIL frame_delay4 c=%0d: got %b want %b", c,
                 {s4_if.hs_d, s4_if.vs_d, s4_if.blank_d}, hist[4]);
      end
      if (s2_if.frame_start === 1'b1) fs_cyc.push_back(c);
      if (s2_if.vs === 1'b0) begin
        if (c <= 240) begin
          vs_f1++;
          if (vs_first < 0) vs_first = c;
          vs_last = c;
        end else begin
          vs_f2++;
        end
      end
      if (s2_if.blank === 1'b1) begin
        if (c <= 240) bl_f1++;
        else if (c <= 480) bl_f2++;
      end
    end
    tests++;
    if (fs_cyc.size() != 3) begin
      fails++; $display("FAIL frame_fs_count: got %0d want 3", fs_cyc.size());
    end else begin
      tests++;
      if (fs_cyc[0] != 1 || fs_cyc[1] - fs_cyc[0] != 240 || fs_cyc[2] - fs_cyc[1] != 240) begin
        fails++;
        $display("FAIL frame_fs_period: got cycles %0d,%0d,%0d want 1,241,481",
                 fs_cyc[0], fs_cyc[1], fs_cyc[2]);
      end
    end
    tests++;
    if (vs_f1 != 40 || vs_f2 != 40 || vs_first != 141 || vs_last != 180) begin
      fails++;
      $display("FAIL frame_vsync: got %0d/%0d cycles span %0d..%0d want 40/40 span 141..180",
               vs_f1, vs_f2, vs_first, vs_last);
    end
    tests++;
    if (bl_f1 != 60 || bl_f2 != 60) begin
      fails++; $display("FAIL frame_blank_count: got %0d/%0d want 60/60", bl_f1, bl_f2);
    end
  endtask

  task automatic test_small_mid_reset();
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      model_step();
      if (s2_if.DrawX == 10'd7 && s2_if.DrawY == 10'd4) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL small_reach_7_4: got (%0d,%0d) want (7,4)", s2_if.DrawX, s2_if.DrawY);
    end
    rst_small = 1'b1;
    @(negedge clk);
    model_reset();
    tests++;
    if ({s4_if.DrawX, s4_if.DrawY, s4_if.hs, s4_if.vs, s4_if.blank, s4_if.frame_start,
         s4_if.hs_d, s4_if.vs_d, s4_if.blank_d} !== {10'd19, 10'd11, 7'b1100110}) begin
      fails++;
      $display("FAIL small_mid_reset: got (%0d,%0d) flags=%b want (19,11) flags=1100110",
               s4_if.DrawX, s4_if.DrawY, {s4_if.hs, s4_if.vs, s4_if.blank, s4_if.frame_start,
               s4_if.hs_d, s4_if.vs_d, s4_if.blank_d});
    end
    rst_small = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      model_step();
      tests++;
      if ({s2_if.DrawX, s2_if.DrawY, s2_if.frame_start} !== {mx, my, exp_fs}) begin
        fails++;
        $display("FAIL small_rerun_pos c=%0d: got (%0d,%0d) fs=%b want (%0d,%0d) fs=%b", c,
                 s2_if.DrawX, s2_if.DrawY, s2_if.frame_start, mx, my, exp_fs);
      end
      tests++;
      if ({s0_if.hs_d, s0_if.vs_d, s0_if.blank_d, s2_if.hs_d, s2_if.vs_d, s2_if.blank_d,
           s4_if.hs_d, s4_if.vs_d, s4_if.blank_d} !== {hist[0], hist[2], hist[4]}) begin
        fails++;
        $display("FAIL small_rerun_delay c=%0d: got %b/%b/%b want %b/%b/%b", c,
                 {s0_if.hs_d, s0_if.vs_d, s0_if.blank_d}, {s2_if.hs_d, s2_if.vs_d, s2_if.blank_d},
                 {s4_if.hs_d, s4_if.vs_d, s4_if.blank_d}, hist[0], hist[2], hist[4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line();
    test_mid_reset_big();
    test_small_frames();
    test_small_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
